ssds_display_arbiter: RTL and testbench

//  Shares the 4-digit seven-segment display between REQUESTERS independent sources.

---
 rtl/ssds_display_arbiter.sv | 145 ++++++++++++++
 tb/tb_ssds_display_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ssds_display_arbiter.sv
// Round-robin, time-sliced owner selection for a shared 4-digit seven-segment display.
// Each owner change passes through a single blank tick, so frames from two sources never mix.
module ssds_display_arbiter #(
  parameter int REQUESTERS  = 4,
  parameter int SLICE_TICKS = 240
) (
  input  logic                          refresh_clk,
  input  logic                          rst,
  input  logic [REQUESTERS-1:0]         req,
  input  logic [32*REQUESTERS-1:0]      frames,
  output logic [REQUESTERS-1:0]         grant,
  output logic [$clog2(REQUESTERS)-1:0] owner,
  output logic                          busy,
  output logic [6:0]                    digit_0,
  output logic [6:0]                    digit_1,
  output logic [6:0]                    digit_2,
  output logic [6:0]                    digit_3,
  output logic [3:0]                    dots,
  output logic                          en
);

  localparam int OW = $clog2(REQUESTERS);
  localparam int CW = $clog2(SLICE_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANTED = 2'd1,
    S_SWITCH  = 2'd2
  } state_t;

  state_t          state;
  logic [OW-1:0]   rr;
  logic [CW-1:0]   slice_cnt;

  logic            pick_found;
  logic [OW-1:0]   pick_idx;
  logic [REQUESTERS-1:0] owner_oh;
  logic            others_pending;
  logic            release_now;
  logic            preempt_now;
  logic [31:0]     win_frame;
  logic [31:0]     own_frame;

  // First set request strictly after pointer p, wrapping; returns {found, index}.
  function automatic logic [OW:0] rr_pick(input logic [REQUESTERS-1:0] r,
                                          input logic [OW-1:0] p);
    logic          found;
    logic [OW-1:0] idx;
    int            c;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      c = (int'(p) + k) % REQUESTERS;
      if (!found && r[c]) begin
        found = 1'b1;
        idx   = OW'(c);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [REQUESTERS-1:0] onehot(input logic [OW-1:0] i);
    logic [REQUESTERS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    {pick_found, pick_idx} = rr_pick(req, rr);
    owner_oh       = onehot(owner);
    others_pending = |(req & ~owner_oh);
    release_now    = !req[owner];
    preempt_now    = others_pending && (slice_cnt == CW'(SLICE_TICKS - 1));
    win_frame      = frames[32*int'(pick_idx) +: 32];
    own_frame      = frames[32*int'(owner) +: 32];
  end

  always_ff @(posedge refresh_clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr        <= OW'(REQUESTERS - 1);
      slice_cnt <= '0;
      grant     <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      en        <= 1'b0;
      digit_0   <= '0;
      digit_1   <= '0;
      digit_2   <= '0;
      digit_3   <= '0;
      dots      <= '0;
    end else begin
      case (state)
        S_IDLE, S_SWITCH: begin
          slice_cnt <= '0;
          if (pick_found) begin
            state   <= S_GRANTED;
            rr      <= pick_idx;
            owner   <= pick_idx;
            grant   <= onehot(pick_idx);
            busy    <= 1'b1;
            en      <= 1'b1;
            digit_0 <= win_frame[6:0];
            digit_1 <= win_frame[13:7];
            digit_2 <= win_frame[20:14];
            digit_3 <= win_frame[27:21];
            dots    <= win_frame[31:28];
          end else begin
            state <= S_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            en    <= 1'b0;
          end
        end
        S_GRANTED: begin
          // Owner frame is re-sampled every tick, giving a fixed one-tick lag.
          digit_0 <= own_frame[6:0];
          digit_1 <= own_frame[13:7];
          digit_2 <= own_frame[20:14];
          digit_3 <= own_frame[27:21];
          dots    <= own_frame[31:28];
          if (release_now || preempt_now) begin
            state     <= S_SWITCH;
            grant     <= '0;
            busy      <= 1'b0;
            en        <= 1'b0;
            slice_cnt <= '0;
          end else if (!others_pending) begin
            slice_cnt <= '0;
          end else if (slice_cnt != CW'(SLICE_TICKS)) begin
            slice_cnt <= slice_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
          busy  <= 1'b0;
          en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssds_display_arbiter.sv
// Directed bench for ssds_display_arbiter: vector table for the round-robin rotation
// plus hand-written sequences for reset, release, simultaneous events and frame tracking.
module tb_ssds_display_arbiter;

  logic         refresh_clk = 1'b0;
  logic         rst         = 1'b1;
  logic [3:0]   req         = '0;
  logic [127:0] frames      = '0;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic         busy;
  logic [6:0]   digit_0, digit_1, digit_2, digit_3;
  logic [3:0]   dots;
  logic         en;

  int checks   = 0;
  int failures = 0;

  ssds_display_arbiter #(.REQUESTERS(4), .SLICE_TICKS(4)) dut (
    .refresh_clk(refresh_clk), .rst(rst), .req(req), .frames(frames),
    .grant(grant), .owner(owner), .busy(busy),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .dots(dots), .en(en)
  );

  always #5 refresh_clk = ~refresh_clk;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       en;
    logic [6:0] d0;
  } row_t;

  row_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge refresh_clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [6:0] d;
    d = 7'(8'h11 * (i + 1));
    return {4'(i + 1), d, d, d, d};
  endfunction

  initial begin
    logic [31:0] v;
    logic [31:0] prev;

    tbl[0]  = '{4'b0001, 2'd0, 1'b1, 7'h11}; tbl[1]  = '{4'b0001, 2'd0, 1'b1, 7'h11};
    tbl[2]  = '{4'b0001, 2'd0, 1'b1, 7'h11}; tbl[3]  = '{4'b0001, 2'd0, 1'b1, 7'h11};
    tbl[4]  = '{4'b0000, 2'd0, 1'b0, 7'h11};
    tbl[5]  = '{4'b0010, 2'd1, 1'b1, 7'h22}; tbl[6]  = '{4'b0010, 2'd1, 1'b1, 7'h22};
    tbl[7]  = '{4'b0010, 2'd1, 1'b1, 7'h22}; tbl[8]  = '{4'b0010, 2'd1, 1'b1, 7'h22};
    tbl[9]  = '{4'b0000, 2'd1, 1'b0, 7'h22};
    tbl[10] = '{4'b0100, 2'd2, 1'b1, 7'h33}; tbl[11] = '{4'b0100, 2'd2, 1'b1, 7'h33};
    tbl[12] = '{4'b0100, 2'd2, 1'b1, 7'h33}; tbl[13] = '{4'b0100, 2'd2, 1'b1, 7'h33};
    tbl[14] = '{4'b0000, 2'd2, 1'b0, 7'h33};
    tbl[15] = '{4'b1000, 2'd3, 1'b1, 7'h44}; tbl[16] = '{4'b1000, 2'd3, 1'b1, 7'h44};
    tbl[17] = '{4'b1000, 2'd3, 1'b1, 7'h44}; tbl[18] = '{4'b1000, 2'd3, 1'b1, 7'h44};
    tbl[19] = '{4'b0000, 2'd3, 1'b0, 7'h44};
    tbl[20] = '{4'b0001, 2'd0, 1'b1, 7'h11};

    // Reset state
    step(); step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_en",    32'(en),    32'h0);
    chk("rst_d0",    32'(digit_0), 32'h0);
    chk("rst_dots",  32'(dots),  32'h0);
    rst = 1'b0;

    // Single requester, held indefinitely
    req = 4'b0100;
    frames[64 +: 32] = 32'hA5A5_1234;
    step();
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_en",    32'(en),    32'h1);
    chk("single_busy",  32'(busy),  32'h1);
    chk("single_d0",    32'(digit_0), 32'h34);
    chk("single_d1",    32'(digit_1), 32'h24);
    chk("single_dots",  32'(dots),    32'hA);
    repeat (10) step();
    chk("hold_grant", 32'(grant), 32'h4);
    chk("hold_en",    32'(en),    32'h1);

    // Release with nobody waiting -> SWITCH then IDLE
    req = 4'b0000;
    step();
    chk("rel_sw_en",    32'(en),    32'h0);
    chk("rel_sw_grant", 32'(grant), 32'h0);
    chk("rel_sw_busy",  32'(busy),  32'h0);
    step();
    chk("rel_idle_en",    32'(en),    32'h0);
    chk("rel_idle_owner", 32'(owner), 32'h2);
    chk("rel_idle_d0",    32'(digit_0), 32'h34);

    // Asynchronous reset mid-GRANTED
    for (int i = 0; i < 4; i++) frames[32*i +: 32] = pat(i);
    req = 4'b1111;
    step();
    chk("pre_rst_owner", 32'(owner), 32'h3);
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_en",    32'(en),    32'h0);
    chk("async_d0",    32'(digit_0), 32'h0);
    chk("async_owner", 32'(owner), 32'h0);
    chk("async_busy",  32'(busy),  32'h0);
    #1 rst = 1'b0;

    // Round-robin rotation with slicing
    for (int r = 0; r < 21; r++) begin
      step();
      chk($sformatf("rr%0d_grant", r), 32'(grant), 32'(tbl[r].grant));
      chk($sformatf("rr%0d_owner", r), 32'(owner), 32'(tbl[r].owner));
      chk($sformatf("rr%0d_en", r),    32'(en),    32'(tbl[r].en));
      chk($sformatf("rr%0d_busy", r),  32'(busy),  32'(tbl[r].en));
      chk($sformatf("rr%0d_d0", r),    32'(digit_0), 32'(tbl[r].d0));
    end

    // Release hands over to a waiting requester after one gap tick
    req = 4'b1010;
    step();
    chk("relA_sw_en", 32'(en), 32'h0);
    step();
    chk("relA_grant", 32'(grant), 32'h2);
    chk("relA_owner", 32'(owner), 32'h1);
    req = 4'b1000;
    step();
    chk("relB_sw_en",    32'(en),    32'h0);
    chk("relB_sw_grant", 32'(grant), 32'h0);
    step();
    chk("relB_grant", 32'(grant), 32'h8);
    chk("relB_owner", 32'(owner), 32'h3);
    chk("relB_d0",    32'(digit_0), 32'h44);
    req = 4'b0000;
    step();
    chk("relC_sw_en", 32'(en), 32'h0);
    step();
    chk("relC_idle_busy", 32'(busy), 32'h0);
    step();
    chk("relC_idle_grant", 32'(grant), 32'h0);

    // Release and slice expiry on the same edge -> single gap
    req = 4'b0011;
    step();
    chk("sim_grant0", 32'(grant), 32'h1);
    step(); step(); step();
    chk("sim_en3", 32'(en), 32'h1);
    req = 4'b0010;
    step();
    chk("sim_sw_en",    32'(en),    32'h0);
    chk("sim_sw_grant", 32'(grant), 32'h0);
    step();
    chk("sim_grant1", 32'(grant), 32'h2);
    chk("sim_en1",    32'(en),    32'h1);

    // Request rising during SWITCH is arbitrated at the exit edge
    req = 4'b0000;
    step();
    chk("late_sw_en", 32'(en), 32'h0);
    req = 4'b0100;
    step();
    chk("late_grant", 32'(grant), 32'h4);
    chk("late_owner", 32'(owner), 32'h2);

    // Owner frame tracked with exactly one tick of lag
    prev = pat(2);
    for (int k = 0; k < 8; k++) begin
      v = 32'h2468_ACE1 + 32'h1357_9BDF * k;
      frames[64 +: 32] = v;
      frames[0 +: 32]  = ~v;
      frames[32 +: 32] = ~v;
      frames[96 +: 32] = ~v;
      #1;
      chk($sformatf("trk%0d_lag_d0", k), 32'(digit_0), 32'(prev[6:0]));
      step();
      chk($sformatf("trk%0d_d0", k),   32'(digit_0), 32'(v[6:0]));
      chk($sformatf("trk%0d_d1", k),   32'(digit_1), 32'(v[13:7]));
      chk($sformatf("trk%0d_d2", k),   32'(digit_2), 32'(v[20:14]));
      chk($sformatf("trk%0d_d3", k),   32'(digit_3), 32'(v[27:21]));
      chk($sformatf("trk%0d_dots", k), 32'(dots),    32'(v[31:28]));
      chk($sformatf("trk%0d_en", k),   32'(en),      32'h1);
      prev = v;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
